// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: start bit, W_MESSAGE data bits LSB first, one stop bit; UART_RX_MAJORITY_EN adds 2-of-3 voting per sample.
// Latency: 3 clocks from rx falling to detection; rx_valid/frame_err arrive one cycle after the mid-stop sample.
// Backpressure: none; each byte is offered for a single cycle and must be taken then.
module uart_rx #(
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int BITRATE       = 1_000_000,
  parameter int W_PACKAGE     = 10,
  parameter int W_MESSAGE     = 8
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 rx,
  output logic [W_MESSAGE-1:0] message,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BITRATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(W_MESSAGE + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT     = HALF;
`else
  localparam int START_PT     = HALF - 1;
`endif
  localparam logic [CW-1:0] START_CNT = CW'(START_PT);
  localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W_MESSAGE - 1);

  generate
    if (W_PACKAGE != W_MESSAGE + 2) begin : g_bad_package
      $error("uart_rx: W_PACKAGE must equal W_MESSAGE + 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLK_FREQUENCY / BITRATE must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s, rx_d;
  logic [1:0]             flush_cnt;
  logic                   line_rdy, start_edge, at_pt, bit_val;
  logic [CW-1:0]          cnt, cnt_nxt, pt_cnt;
  logic [BW-1:0]          bit_idx, bit_nxt;
  logic [W_MESSAGE-1:0]   shift, shift_nxt, msg_nxt;
  logic                   valid_nxt, ferr_nxt;

  // Edges are ignored until the reset values have left the synchronizer, so a
  // line held low across reset release never looks like a start bit.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      flush_cnt <= '0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_d      <= rx_s;
      flush_cnt <= flush_cnt + {1'b0, ~line_rdy};
    end
  end

  assign line_rdy   = &flush_cnt;
  assign start_edge = line_rdy & rx_d & ~rx_s;
  assign pt_cnt     = (state == START) ? START_CNT : BIT_CNT;
  assign at_pt      = (cnt == pt_cnt);
  assign rx_busy    = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
  logic maj_a, maj_b;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (cnt == pt_cnt - CW'(2)) maj_a <= rx_s;
      if (cnt == pt_cnt - CW'(1)) maj_b <= rx_s;
    end
  end

  assign bit_val = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      message   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      message   <= msg_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    msg_nxt   = message;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (start_edge) state_nxt = START;
      end
      START: begin
        if (at_pt) begin
          cnt_nxt   = '0;
          state_nxt = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_pt) begin
          cnt_nxt   = '0;
          shift_nxt = {bit_val, shift[W_MESSAGE-1:1]};
          bit_nxt   = bit_idx + BW'(1);
          if (bit_idx == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start edge half a bit later is still caught.
        if (at_pt) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (bit_val) begin
            msg_nxt   = shift;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers frames produced by `uart_tx`: start bit, `W_MESSAGE` data bits LSB first, one stop bit. It sits on the serial input pin and hands each received byte to the fabric with a one-cycle valid pulse. It is the loopback and consumer partner of `uart_tx` and shares its parameter set and clocking.

## Interface
- `CLK_FREQUENCY`, 40_000_000, system clock frequency in Hz.
- `BITRATE`, 1_000_000, line rate in bit/s. `CLKS_PER_BIT = CLK_FREQUENCY / BITRATE`, truncated, 40 at defaults. `HALF = CLKS_PER_BIT / 2`. Must be ≥ 4.
- `W_PACKAGE`, 10, total frame bits. Must equal `W_MESSAGE + 2`; elaboration error otherwise.
- `W_MESSAGE`, 8, data bits per frame.

Ports:
- `clk`  in  1  system clock; the block has one clock and all logic is on its rising edge.
- `arstn`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  asynchronous serial line; idles high.
- `message`  out  `W_MESSAGE`  last correctly framed data word.
- `rx_valid`  out  1  one-cycle pulse when `message` is updated.
- `rx_busy`  out  1  high while a frame is being received.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.

## Operation
- Input path: `rx` passes through a 2-flop synchronizer and then one edge register, producing `rx_s` and `rx_d`. All three flops reset to 1.
- Start detection is edge-based: `rx_d == 1 && rx_s == 0`. A line held low does not retrigger.
- FSM states and transitions:
  - IDLE: on start edge, clear the bit counter and go to START.
  - START: at count `HALF`, sample the line. If the sample is 1, treat it as a glitch and return to IDLE with no outputs. If 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. Shift each bit into bit `W_MESSAGE-1` of the shift register, moving right, so the first received bit (LSB) ends at bit 0. After `W_MESSAGE` samples, go to STOP.
  - STOP: sample one `CLKS_PER_BIT` later. If 1, load `message` from the shift register and pulse `rx_valid`. If 0, pulse `frame_err` and hold `message`. Return to IDLE in both cases.
- The return to IDLE happens at the mid-stop sample, so a next start edge half a bit later is captured. Back-to-back frames are supported.
- `rx_valid` and `frame_err` are never high together.

## Timing
- Reset values: `message` = 0, `rx_valid` = 0, `rx_busy` = 0, `frame_err` = 0. FSM goes to IDLE and counters clear.
- Reset is immediate, including mid-frame. The partial frame is discarded and no pulse is produced.
- Reset release with `rx` low does not start a frame.
- Latency from `rx` falling to the detection cycle (cycle 0): 3 clocks.
- Sample points, relative to cycle 0:
  - Start bit: cycle `HALF`.
  - Data bit i (i = 0 … `W_MESSAGE`-1): cycle `HALF + (i+1)*CLKS_PER_BIT`.
  - Stop bit: cycle `HALF + (W_MESSAGE+1)*CLKS_PER_BIT`, i.e. 380 at defaults.
- `rx_valid` or `frame_err` is registered and high in the cycle after the stop sample, for exactly one cycle. `message` is valid from that same cycle.
- `rx_busy` is high from cycle 1 through the stop-sample cycle. It is low in the cycle `rx_valid` or `frame_err` is high.
- On a glitch rejection, `rx_busy` drops in the cycle after the start sample.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 at each sample point.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample point takes the line at counts `point-1`, `point`, `point+1` and uses the 2-of-3 majority. This applies to the start, data and stop samples. Decision timing is unchanged: the value is used at cycle `point+1`, and all cycle numbers above shift by +1.
- Undefined: a single sample is taken at `point`.

## Test plan
- Single frame, 0x1A, from `uart_tx` in loopback at defaults → `rx_valid` pulses once, `message` = 0x1A, `frame_err` stays 0.
- Back-to-back 0x1A then 0xD6 with a 1-bit stop → two `rx_valid` pulses exactly 400 clocks apart, values 0x1A then 0xD6.
- `rx` low for 10 clocks, then high → `rx_busy` high for about 20 clocks, then low; no `rx_valid`, no `frame_err`; a following 0xE5 frame is received correctly.
- Frame 0xE5 with stop bit driven 0, then line held low for 2000 clocks → one `frame_err` pulse; `message` keeps its prior value; no further activity until the line rises and a new start edge arrives.
- `arstn` asserted during data bit 4 → all outputs 0 asynchronously; after release, a 0xE5 frame is received correctly.
- 1-clock inverted spike at the centre of data bit 3 of 0x1A → with `UART_RX_MAJORITY_EN`, `message` = 0x1A; without it, `message` = 0x12.
